pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generalises the fixed-width, stall-only stage register:
  - configurable control and data widths
  - valid/ready handshake
  - synchronous flush with bubble insertion
  - optional skid entry, which breaks the combinational ready path
  - saturating bubble counter for performance monitoring

Parameters:
CTRL_W, 4, width of control bundle; forced to zero in bubbles
DATA_W, 69, width of payload bundle (ALU result, RS2 data, RD address)
SKID, 1, 1 = two-entry stage (main + skid), registered ready_o; 0 = single entry, combinational ready_o
CNT_W, 16, width of bubble counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
stall_i  input  1  global freeze: no register updates, no transfers
flush_i  input  1  synchronous kill of all held entries
valid_i  input  1  upstream beat valid
ready_o  output  1  stage can accept a beat
ctrl_i  input  CTRL_W  upstream control bundle
data_i  input  DATA_W  upstream payload
valid_o  output  1  main entry holds a valid beat
ready_i  input  1  downstream accepts the beat
ctrl_o  output  CTRL_W  control of main entry; all-zero when valid_o=0
data_o  output  DATA_W  payload of main entry
bubble_cnt_o  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_i=0, asynchronous, at any time, including mid-transfer):
  - M_valid=0, S_valid=0
  - ctrl_o=0, data_o=0
  - skid contents=0
  - bubble_cnt_o=0
- Definitions:
  - in_xfer = valid_i & ready_o
  - out_xfer = valid_o & ready_i & ~stall_i
- ready_o:
  - SKID=1: ready_o = ~S_valid & ~stall_i & ~flush_i (no dependence on ready_i)
  - SKID=0: ready_o = ~stall_i & ~flush_i & (~M_valid | ready_i)
- Priority per edge: reset > flush_i > stall_i > normal update.
- Flush: next edge M_valid=0, S_valid=0, ctrl_o=0. data_o holds its value. The upstream beat is not accepted because ready_o=0. flush_i wins when asserted together with stall_i.
- Stall: all state holds, including bubble_cnt_o. valid_o, ctrl_o and data_o stay stable.
- Normal update, SKID=1:
  - If out_xfer or ~M_valid:
    - M loads S when S_valid=1.
    - Otherwise M loads the input beat when in_xfer=1.
    - Otherwise M becomes empty (M_valid=0, ctrl_o=0).
    - S_valid becomes 0.
  - Else (M full and held): if in_xfer, S captures ctrl_i/data_i and S_valid becomes 1.
  - The case S_valid & in_xfer cannot occur.
- Normal update, SKID=0: if out_xfer or ~M_valid, M loads the input beat when in_xfer=1, else becomes empty.
- Latency and throughput:
  - Empty stage: beat appears on outputs 1 cycle after in_xfer.
  - Sustained throughput: 1 beat/cycle.
  - Ordering is strictly FIFO; no beat is lost or duplicated.
- Bubble counter: increments by 1 on each edge where ~stall_i & ~M_valid. Saturates at 2^CNT_W-1 with no wrap. Not cleared by flush.
- Payload is passed bit-exact; no arithmetic on data.

Test Plan:
- Reset then stream: rst_i low 2 cycles, then valid_i=1 with data 1..8, ready_i=1.
  - Required: data_o=1 one cycle after first accept, then 2..8 on consecutive cycles.
  - Required: ready_o=1 throughout; bubble_cnt_o counts only the idle cycles.
- Backpressure, SKID=1: M holds 0xA and S holds 0xB, ready_i=0 for 3 cycles.
  - Required: ready_o=0 and data_o=0xA held.
  - Then ready_i=1: outputs 0xA, 0xB, then the next input in order; none lost.
- Stall: stall_i=1 for 4 cycles mid-stream with data_o=0x5.
  - Required: ready_o=0; data_o=0x5 and valid_o=1 unchanged; bubble_cnt_o unchanged.
  - After release: stream resumes with 0x6.
- Flush with stall: M and S full, assert flush_i together with stall_i for 1 cycle.
  - Required next cycle: valid_o=0, ctrl_o=0, ready_o=1; the beat presented during flush is not accepted.
- Async reset mid-transfer: drop rst_i between clock edges while valid_o=1.
  - Required: all outputs zero immediately, before the next clock edge.
- Counter saturation, CNT_W=3: idle for 10 cycles.
  - Required: bubble_cnt_o reaches 7 and stays at 7.
- SKID=0 variant: ready_i=0 with M full.
  - Required: ready_o=0 in the same cycle; ready_o returns to 1 in the same cycle ready_i rises.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ----------------------------------------------------------------------------
// Parametrised pipeline-stage register for inter-stage boundaries
// (IF/ID, ID/EX, EX/MEM, MEM/WB). A valid/ready handshake moves beats through
// a main entry (M) that drives the outputs. With SKID=1 a second skid entry
// (S) absorbs one beat while M is held, so ready_o is a pure function of
// local state plus stall/flush and does not depend on ready_i. With SKID=0
// the stage has a single entry and ready_o looks through to ready_i.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous reset, active low
//   stall_i       global freeze: no state updates, no transfers
//   flush_i       synchronous kill of all held entries (wins over stall_i)
//   valid_i       upstream beat valid
//   ready_o       stage can accept a beat
//   ctrl_i        upstream control bundle (CTRL_W)
//   data_i        upstream payload (DATA_W)
//   valid_o       main entry holds a valid beat
//   ready_i       downstream accepts the beat
//   ctrl_o        control of main entry, all-zero whenever valid_o=0
//   data_o        payload of main entry (holds its last value when empty)
//   bubble_cnt_o  saturating count of edges with M empty and no stall
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              m_valid_r;
  logic [CTRL_W-1:0] m_ctrl_r;
  logic [DATA_W-1:0] m_data_r;
  logic              s_valid_r;
  logic [CTRL_W-1:0] s_ctrl_r;
  logic [DATA_W-1:0] s_data_r;
  logic [CNT_W-1:0]  bubble_cnt_r;

  logic              ready_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              m_take_s;

  // Acceptance: skid variant only looks at its own skid slot, single-entry
  // variant must see the downstream ready to free M in the same cycle.
  always_comb begin
    ready_s = 1'b0;
    if (SKID != 0) begin
      ready_s = ~s_valid_r & ~stall_i & ~flush_i;
    end else begin
      ready_s = ~stall_i & ~flush_i & (~m_valid_r | ready_i);
    end
  end

  // Handshake qualifiers; m_take_s means M is free to load on this edge.
  always_comb begin
    in_xfer_s  = valid_i & ready_s;
    out_xfer_s = m_valid_r & ready_i & ~stall_i;
    m_take_s   = out_xfer_s | ~m_valid_r;
  end

  // Main entry: S drains into M before any new input so ordering stays FIFO.
  // When M empties, ctrl is cleared but data keeps its last value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_valid_r <= 1'b0;
      m_ctrl_r  <= {CTRL_W{1'b0}};
      m_data_r  <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      m_valid_r <= 1'b0;
      m_ctrl_r  <= {CTRL_W{1'b0}};
    end else if (stall_i) begin
      m_valid_r <= m_valid_r;
    end else if (m_take_s) begin
      if (s_valid_r) begin
        m_valid_r <= 1'b1;
        m_ctrl_r  <= s_ctrl_r;
        m_data_r  <= s_data_r;
      end else if (in_xfer_s) begin
        m_valid_r <= 1'b1;
        m_ctrl_r  <= ctrl_i;
        m_data_r  <= data_i;
      end else begin
        m_valid_r <= 1'b0;
        m_ctrl_r  <= {CTRL_W{1'b0}};
      end
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  // Skid entry: captures an accepted beat only while M is full and held.
  // ready_o is low whenever S is full, so S never overflows.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_valid_r <= 1'b0;
      s_ctrl_r  <= {CTRL_W{1'b0}};
      s_data_r  <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      s_valid_r <= 1'b0;
    end else if (stall_i) begin
      s_valid_r <= s_valid_r;
    end else if (m_take_s) begin
      s_valid_r <= 1'b0;
    end else if (in_xfer_s && (SKID != 0)) begin
      s_valid_r <= 1'b1;
      s_ctrl_r  <= ctrl_i;
      s_data_r  <= data_i;
    end else begin
      s_valid_r <= s_valid_r;
    end
  end

  // Bubble counter: counts non-stalled edges with M empty, saturating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!stall_i && !m_valid_r && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign ready_o      = ready_s;
  assign valid_o      = m_valid_r;
  assign ctrl_o       = m_ctrl_r;
  assign data_o       = m_data_r;
  assign bubble_cnt_o = bubble_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. Three instances share one input stream:
//   0: SKID=1, CNT_W=16   1: SKID=0, CNT_W=16   2: SKID=1, CNT_W=3
// Each instance is compared every cycle against a capacity-bounded FIFO
// model (capacity 2 with skid, 1 without), plus directed checks.
module tb_pipe_stage_reg;

  logic        clk_i;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [3:0]  ctrl_i;
  logic [68:0] data_i;

  logic        rdy_o [3];
  logic        vld_o [3];
  logic [3:0]  ctl_o [3];
  logic [68:0] dat_o [3];
  logic [15:0] bc_a;
  logic [15:0] bc_b;
  logic [2:0]  bc_c;

  int tests = 0;
  int fails = 0;

  // Reference model: each stage is a FIFO of beats {ctrl,data}.
  logic [72:0] mq    [3][2];
  int          mcnt  [3];
  logic [68:0] mlast [3];
  int          mbub  [3];
  int          cap   [3] = '{2, 1, 2};
  int          bmax  [3] = '{65535, 65535, 7};

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(rdy_o[0]), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(vld_o[0]), .ready_i(ready_i), .ctrl_o(ctl_o[0]), .data_o(dat_o[0]),
    .bubble_cnt_o(bc_a));

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(0), .CNT_W(16)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(rdy_o[1]), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(vld_o[1]), .ready_i(ready_i), .ctrl_o(ctl_o[1]), .data_o(dat_o[1]),
    .bubble_cnt_o(bc_b));

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1), .CNT_W(3)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(rdy_o[2]), .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(vld_o[2]), .ready_i(ready_i), .ctrl_o(ctl_o[2]), .data_o(dat_o[2]),
    .bubble_cnt_o(bc_c));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bub_obs(int i);
    case (i)
      0:       return bc_a;
      1:       return bc_b;
      default: return {13'd0, bc_c};
    endcase
  endfunction

  function automatic logic mready(int i);
    return !stall_i && !flush_i && (mcnt[i] < cap[i] || (cap[i] == 1 && ready_i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i]  = 0;
      mlast[i] = 69'd0;
      mbub[i]  = 0;
    end
  endtask

  task automatic bub_inc(int i);
    if (mbub[i] < bmax[i]) mbub[i]++;
  endtask

  // Apply one clock edge to the model using the current (pre-edge) inputs.
  task automatic model_edge();
    logic acc;
    for (int i = 0; i < 3; i++) begin
      acc = valid_i && mready(i);
      if (flush_i) begin
        if (!stall_i && mcnt[i] == 0) bub_inc(i);
        mcnt[i] = 0;
      end else if (!stall_i) begin
        if (mcnt[i] == 0) bub_inc(i);
        if (mcnt[i] > 0 && ready_i) begin
          mq[i][0] = mq[i][1];
          mcnt[i]--;
        end
        if (acc) begin
          mq[i][mcnt[i]] = {ctrl_i, data_i};
          mcnt[i]++;
        end
      end
      if (mcnt[i] > 0) mlast[i] = mq[i][0][68:0];
    end
  endtask

  task automatic check_outs();
    logic [3:0] ec;
    for (int i = 0; i < 3; i++) begin
      ec = (mcnt[i] > 0) ? mq[i][0][72:69] : 4'h0;
      chk($sformatf("valid_o%0d", i), 80'(vld_o[i]), 80'(mcnt[i] > 0));
      chk($sformatf("ctrl_o%0d", i), 80'(ctl_o[i]), 80'(ec));
      chk($sformatf("data_o%0d", i), 80'(dat_o[i]), 80'(mlast[i]));
      chk($sformatf("bubble%0d", i), 80'(bub_obs(i)), 80'(mbub[i]));
    end
  endtask

  // One cycle: drive inputs after the falling edge, check ready_o, clock,
  // then check registered outputs 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [68:0] d,
                      input logic rdy, input logic st, input logic fl);
    valid_i = v; ctrl_i = c; data_i = d; ready_i = rdy; stall_i = st; flush_i = fl;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("ready_o%0d", i), 80'(rdy_o[i]), 80'(mready(i)));
    model_edge();
    @(posedge clk_i);
    #1;
    check_outs();
    @(negedge clk_i);
  endtask

  initial begin
    logic [15:0] held_bub;
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    ready_i = 1'b0; ctrl_i = 4'h0; data_i = 69'd0;
    model_reset();

    // Reset held for two edges
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check_outs();
    rst_i = 1'b1;

    // Stream 1..8 at full rate
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 4'(k) | 4'h1, 69'(k), 1'b1, 1'b0, 1'b0);
      chk("stream_data", 80'(dat_o[0]), 80'(k));
    end
    step(1'b0, 4'h0, 69'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: M=A, S=B, then hold for three cycles
    step(1'b1, 4'h2, 69'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h3, 69'hB, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'h4, 69'hC, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", 80'(dat_o[0]), 80'(69'hA));
    end
    step(1'b1, 4'h4, 69'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_b", 80'(dat_o[0]), 80'(69'hB));
    step(1'b1, 4'h4, 69'hC, 1'b1, 1'b0, 1'b0);
    chk("bp_drain_c", 80'(dat_o[0]), 80'(69'hC));

    // Stall for four cycles with 0x5 on the outputs
    step(1'b1, 4'h5, 69'h5, 1'b1, 1'b0, 1'b0);
    chk("pre_stall", 80'(dat_o[0]), 80'(69'h5));
    held_bub = 16'(mbub[0]);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'h6, 69'h6, 1'b1, 1'b1, 1'b0);
      chk("stall_data", 80'(dat_o[0]), 80'(69'h5));
      chk("stall_valid", 80'(vld_o[0]), 80'(1'b1));
      chk("stall_bubble", 80'(bc_a), 80'(held_bub));
    end
    step(1'b1, 4'h6, 69'h6, 1'b1, 1'b0, 1'b0);
    chk("stall_resume", 80'(dat_o[0]), 80'(69'h6));

    // Flush together with stall while M and S are full
    step(1'b1, 4'h7, 69'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h7, 69'h12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h9, 69'h13, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", 80'(vld_o[0]), 80'(1'b0));
    chk("flush_ctrl", 80'(ctl_o[0]), 80'(4'h0));
    stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("flush_ready", 80'(rdy_o[0]), 80'(1'b1));
    step(1'b1, 4'hA, 69'h14, 1'b1, 1'b0, 1'b0);
    chk("flush_next", 80'(dat_o[0]), 80'(69'h14));

    // SKID=0: ready_o follows ready_i combinationally while M is full
    step(1'b1, 4'hB, 69'h21, 1'b1, 1'b0, 1'b0);
    valid_i = 1'b1; ready_i = 1'b0;
    #1;
    chk("noskid_rdy_lo", 80'(rdy_o[1]), 80'(1'b0));
    ready_i = 1'b1;
    #1;
    chk("noskid_rdy_hi", 80'(rdy_o[1]), 80'(1'b1));
    step(1'b1, 4'hC, 69'h22, 1'b1, 1'b0, 1'b0);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), {5'($urandom), $urandom, $urandom},
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    // Async reset between edges while a beat is held
    step(1'b1, 4'hD, 69'h33, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 80'(vld_o[0]), 80'(1'b1));
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk_i);
    rst_i = 1'b1;

    // Idle for 10 cycles: the 3-bit counter saturates at 7
    for (int k = 0; k < 10; k++) step(1'b0, 4'h0, 69'd0, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt", 80'(bc_c), 80'(3'd7));
    chk("wide_cnt", 80'(bc_a), 80'(16'd10));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
